// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU command path: FSM state encoding,
// default widths and the opcode values understood by the external ALU.
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_OP_BITS   = 6;
  localparam int STATE_BITS    = 3;

  typedef enum logic [STATE_BITS-1:0] {
    S_A       = 3'd0,
    S_B       = 3'd1,
    S_OP      = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  localparam logic [DEF_OP_BITS-1:0] OP_ADD = 6'h20;
  localparam logic [DEF_OP_BITS-1:0] OP_SUB = 6'h22;
  localparam logic [DEF_OP_BITS-1:0] OP_AND = 6'h24;
  localparam logic [DEF_OP_BITS-1:0] OP_OR  = 6'h25;
  localparam logic [DEF_OP_BITS-1:0] OP_XOR = 6'h26;
  localparam logic [DEF_OP_BITS-1:0] OP_SRA = 6'h03;
  localparam logic [DEF_OP_BITS-1:0] OP_SRL = 6'h02;
  localparam logic [DEF_OP_BITS-1:0] OP_NOR = 6'h27;

  // True while the sequencer is still collecting command bytes.
  function automatic logic is_collect(input state_t st);
    return (st == S_A) || (st == S_B) || (st == S_OP);
  endfunction

endpackage

// File: rtl/uart_alu_if.sv
// Sequencer between UART RX, the combinational ALU and UART TX.
// Optional inter-byte timeout is enabled by defining UART_ALU_IF_TIMEOUT_EN.
//
//  state     | meaning
//  S_A       | idle, waiting for operand A
//  S_B       | waiting for operand B
//  S_OP      | waiting for opcode
//  S_EXEC    | ALU settling, result captured into tx_data
//  S_SEND    | waiting for transmitter idle, then pulse tx_start
//  S_WAIT_TX | waiting for tx_done
module uart_alu_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int OP_BITS        = DEF_OP_BITS,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_ferr,
  output logic [DATA_BITS-1:0] alu_a,
  output logic [DATA_BITS-1:0] alu_b,
  output logic [OP_BITS-1:0]   alu_op,
  input  logic [DATA_BITS-1:0] alu_result,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 err_pulse,
  output logic                 ovr_pulse,
  output logic                 tmo_pulse
);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] alu_a_d, alu_b_d, tx_data_d;
  logic [OP_BITS-1:0]   alu_op_d;
  logic                 tx_start_d, err_d, ovr_d, tmo_d;
  logic                 byte_ok, byte_bad;

  assign byte_ok  = rx_valid & ~rx_ferr;
  assign byte_bad = rx_valid & rx_ferr;
  assign busy     = (state_q != S_A);

`ifdef UART_ALU_IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      err_pulse <= 1'b0;
      ovr_pulse <= 1'b0;
      tmo_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_op    <= alu_op_d;
      tx_data   <= tx_data_d;
      tx_start  <= tx_start_d;
      err_pulse <= err_d;
      ovr_pulse <= ovr_d;
      tmo_pulse <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a;
    alu_b_d    = alu_b;
    alu_op_d   = alu_op;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    tmo_d      = 1'b0;
`ifdef UART_ALU_IF_TIMEOUT_EN
    tmo_cnt_d  = '0;
`endif

    // A byte arriving while a command is in flight cannot be queued.
    ovr_d = rx_valid & ~is_collect(state_q);

    case (state_q)
      S_A: begin
        if (byte_bad) begin
          err_d = 1'b1;
        end else if (byte_ok) begin
          alu_a_d = rx_data;
          state_d = S_B;
        end
      end

      S_B: begin
        if (byte_bad) begin
          err_d   = 1'b1;
          state_d = S_A;
        end else if (byte_ok) begin
          alu_b_d = rx_data;
          state_d = S_OP;
        end
`ifdef UART_ALU_IF_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_A;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      S_OP: begin
        if (byte_bad) begin
          err_d   = 1'b1;
          state_d = S_A;
        end else if (byte_ok) begin
          alu_op_d = rx_data[OP_BITS-1:0];
          state_d  = S_EXEC;
        end
`ifdef UART_ALU_IF_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_A;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      S_EXEC: begin
        tx_data_d = alu_result;
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = S_WAIT_TX;
        end
      end

      S_WAIT_TX: begin
        if (tx_done) state_d = S_A;
      end

      default: state_d = S_A;
    endcase
  end

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed self-checking bench for uart_alu_if with a small behavioural ALU.
module tb_uart_alu_if;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ferr = 1'b0;
  logic [7:0] alu_a, alu_b, alu_result, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, err_pulse, ovr_pulse, tmo_pulse;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_alu_if #(.DATA_BITS(8), .OP_BITS(6), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .busy(busy), .err_pulse(err_pulse), .ovr_pulse(ovr_pulse), .tmo_pulse(tmo_pulse)
  );

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_SRL:  alu_result = alu_a >> alu_b[2:0];
      OP_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[2:0]);
      default: alu_result = 8'h00;
    endcase
  end

  task automatic send_byte(input logic [7:0] d, input logic f);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_ferr  = f;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  // Counts cycles from the opcode-sampling edge until tx_start is seen (bounded).
  task automatic wait_start(output int cyc);
    cyc = 1;
    while (!tx_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] outs;
    repeat (3) @(negedge clk);
    outs = {alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_pulse, ovr_pulse, tmo_pulse};
    checks++;
    if (outs !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    int extra;
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0);
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
      errors++;
      $display("FAIL basic_operands: got a=%h b=%h op=%h expected 05 03 20", alu_a, alu_b, alu_op);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    wait_start(cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles expected 3", cyc);
    end
    checks++;
    if (tx_data !== 8'h08) begin
      errors++;
      $display("FAIL basic_tx_data: got %h expected 08", tx_data);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      extra += int'(tx_start);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL basic_single_start: got %0d extra pulses expected 0", extra);
    end
    pulse_done();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_tx_busy();
    int starts;
    tx_busy = 1'b1;
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0);
    starts = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      tx_done = (i == 4);
      starts += int'(tx_start);
    end
    tx_done = 1'b0;
    checks++;
    if (starts !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_holdoff: got starts=%0d busy=%b expected 0 1", starts, busy);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
      errors++;
      $display("FAIL busy_release_start: got start=%b data=%h expected 1 08", tx_start, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_width: got %b expected 0", tx_start);
    end
    pulse_done();
  endtask

  task automatic test_ferr();
    int cyc;
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0B, 1'b1);
    checks++;
    if ({err_pulse, busy, alu_a, alu_b} !== {1'b1, 1'b0, 8'h0A, 8'h03}) begin
      errors++;
      $display("FAIL ferr_discard: got err=%b busy=%b a=%h b=%h expected 1 0 0a 03",
               err_pulse, busy, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL ferr_pulse_width: got %b expected 0", err_pulse);
    end
    send_byte(8'h0F, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h22, 1'b0);
    wait_start(cyc);
    checks++;
    if (cyc !== 3 || tx_data !== 8'h0E) begin
      errors++;
      $display("FAIL ferr_recover: got cyc=%0d data=%h expected 3 0e", cyc, tx_data);
    end
    pulse_done();
  endtask

  task automatic test_overrun();
    int cyc;
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h25, 1'b0);
    wait_start(cyc);
    send_byte(8'h55, 1'b0);
    checks++;
    if ({ovr_pulse, busy, alu_a, alu_b, alu_op} !== {1'b1, 1'b1, 8'h10, 8'h20, 6'h25}) begin
      errors++;
      $display("FAIL ovr_drop: got ovr=%b busy=%b a=%h b=%h op=%h expected 1 1 10 20 25",
               ovr_pulse, busy, alu_a, alu_b, alu_op);
    end
    checks++;
    if (tx_data !== 8'h30) begin
      errors++;
      $display("FAIL ovr_tx_data: got %h expected 30", tx_data);
    end
    pulse_done();
    checks++;
    if (busy !== 1'b0 || ovr_pulse !== 1'b0) begin
      errors++;
      $display("FAIL ovr_done: got busy=%b ovr=%b expected 0 0", busy, ovr_pulse);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hE6, 1'b0);
    checks++;
    if (alu_op !== 6'h26) begin
      errors++;
      $display("FAIL op_mask: got %h expected 26", alu_op);
    end
    wait_start(cyc);
    checks++;
    if (cyc !== 3 || tx_data !== 8'hCC) begin
      errors++;
      $display("FAIL ovr_next_cmd: got cyc=%0d data=%h expected 3 cc", cyc, tx_data);
    end
    pulse_done();
  endtask

  task automatic test_reset_mid();
    logic [36:0] outs;
    int starts;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    checks++;
    if (busy !== 1'b1 || alu_b !== 8'h22) begin
      errors++;
      $display("FAIL rstmid_pre: got busy=%b b=%h expected 1 22", busy, alu_b);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_pulse, ovr_pulse, tmo_pulse};
    checks++;
    if (outs !== 37'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      starts += int'(tx_start);
    end
    checks++;
    if (starts !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_start: got starts=%0d busy=%b expected 0 0", starts, busy);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    send_byte(8'h33, 1'b0);
`ifdef UART_ALU_IF_TIMEOUT_EN
    cyc = 0;
    while (!tmo_pulse && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 50 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: got cyc=%0d busy=%b expected 50 0", cyc, busy);
    end
    @(negedge clk);
    checks++;
    if (tmo_pulse !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: got %b expected 0", tmo_pulse);
    end
`else
    cyc = 0;
    repeat (60) begin
      @(negedge clk);
      cyc += int'(tmo_pulse);
    end
    checks++;
    if (cyc !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_off: got tmo=%0d busy=%b expected 0 1", cyc, busy);
    end
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    wait_start(cyc);
    checks++;
    if (cyc !== 3 || tx_data !== 8'h34) begin
      errors++;
      $display("FAIL timeout_off_cmd: got cyc=%0d data=%h expected 3 34", cyc, tx_data);
    end
    pulse_done();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx_busy();
    test_ferr();
    test_overrun();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
